// File: rtl/seg7_pkg.sv
// seg7_pkg: shared hex-to-segment table and blank pattern for the 7-segment scan driver
package seg7_pkg;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [7:0] SEG_OFF = 8'hFF;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/control inputs and segment/select outputs of one display bank
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] digit_en;
  logic lz_blank;
  logic [BRIGHT_W-1:0] brightness;
  logic [7:0] seg;
  logic [DIGITS-1:0] sel;
  logic frame_start;
  modport master(output value, dp, digit_en, lz_blank, brightness, input seg, sel, frame_start);
  modport slave(input value, dp, digit_en, lz_blank, brightness, output seg, sel, frame_start);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high a..g pattern (a on bit 0)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  assign pattern = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit common-anode scanner with blanking, PWM and frame latching
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BRIGHT_W = 4
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] slot;
  logic [IW-1:0] idx;
  logic [BRIGHT_W-1:0] pwm;
  logic [4*DIGITS-1:0] sh_value, v;
  logic [DIGITS-1:0] sh_dp, sh_en, dp_e, en_e;
  logic sh_lz, lz, frame, zero_above, cur_dp, cur_en, cur_sup, pwm_on, lit;
  logic [3:0] nib;
  logic [6:0] pat;
  logic [7:0] seg_q;
  logic [DIGITS-1:0] sel_q;
  logic fs_q;
  assign frame = slot == '0 && idx == '0;
  // Bypass the shadows on the latch cycle so the whole frame sees one snapshot
  assign v = frame ? bus.value : sh_value;
  assign dp_e = frame ? bus.dp : sh_dp;
  assign en_e = frame ? bus.digit_en : sh_en;
  assign lz = frame ? bus.lz_blank : sh_lz;
  assign pwm_on = pwm < bus.brightness || &bus.brightness;
  always_comb begin
    zero_above = 1'b1;
    nib = 4'h0;
    cur_dp = 1'b0;
    cur_en = 1'b0;
    cur_sup = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && v[4*i +: 4] == 4'h0;
      if (idx == IW'(i)) begin
        nib = v[4*i +: 4];
        cur_dp = dp_e[i];
        cur_en = en_e[i];
        cur_sup = lz && zero_above && i != 0;
      end
    end
  end
  seg7_hex_decode u_dec (.nibble(nib), .pattern(pat));
  assign lit = slot >= CW'(BLANK_CYCLES) && cur_en && !cur_sup && pwm_on;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      idx <= '0;
      pwm <= '0;
      sh_value <= '0;
      sh_dp <= '0;
      sh_en <= '0;
      sh_lz <= 1'b0;
      seg_q <= SEG_OFF;
      sel_q <= '1;
      fs_q <= 1'b0;
    end else begin
      slot <= slot == CW'(CLK_DIV - 1) ? '0 : slot + 1'b1;
      if (slot == CW'(CLK_DIV - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      pwm <= pwm + 1'b1;
      if (frame) begin
        sh_value <= bus.value;
        sh_dp <= bus.dp;
        sh_en <= bus.digit_en;
        sh_lz <= bus.lz_blank;
      end
      fs_q <= frame;
      seg_q <= lit ? ~{cur_dp, pat} : SEG_OFF;
      sel_q <= lit ? ~(DIGITS'(1) << idx) : '1;
    end
  end
  assign bus.seg = seg_q;
  assign bus.sel = sel_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus on a 4-digit and a 6-digit scanner vs a timing model
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] value = 24'h561234;
  logic [5:0] dp = 6'h0, en = 6'h3F;
  logic lz = 1'b0;
  logic [1:0] br = 2'd3;
  int t = 0, n_chk = 0, n_pass = 0;
  logic [23:0] s4_v, s6_v;
  logic [5:0] s4_d, s4_e, s6_d, s6_e;
  logic s4_l, s6_l;
  logic [14:0] e4, e6;
  logic [6:0] segs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  seg7_scan_driver_if #(.DIGITS(4), .BRIGHT_W(2)) b4 ();
  seg7_scan_driver_if #(.DIGITS(6), .BRIGHT_W(2)) b6 ();
  assign b4.value = value[15:0];
  assign b4.dp = dp[3:0];
  assign b4.digit_en = en[3:0];
  assign b4.lz_blank = lz;
  assign b4.brightness = br;
  assign b6.value = value;
  assign b6.dp = dp;
  assign b6.digit_en = en;
  assign b6.lz_blank = lz;
  assign b6.brightness = br;
  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .BRIGHT_W(2)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  seg7_scan_driver #(.DIGITS(6), .CLK_DIV(8), .BLANK_CYCLES(2), .BRIGHT_W(2)) dut6 (
    .clk(clk), .rst(rst), .bus(b6.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    else n_pass++;
  endtask
  // Expected {frame_start, sel, seg} after edge number tt, from slot timing arithmetic
  function automatic logic [14:0] model(input int n, input logic [23:0] v, input logic [5:0] d,
                                        input logic [5:0] e, input logic l, input logic [1:0] b,
                                        input int tt);
    int slot, dg, pw;
    logic [31:0] upper;
    logic [3:0] nib;
    logic on;
    logic [5:0] sl;
    logic [7:0] sg;
    slot = tt % 8;
    dg = (tt / 8) % n;
    pw = tt % 4;
    upper = ({8'h0, v} >> (4 * dg)) & ((32'h1 << (4 * (n - dg))) - 32'h1);
    nib = v[4*dg +: 4];
    on = slot >= 2 && e[dg] && !(l && dg > 0 && upper == 0) && (b == 2'd3 || pw < int'(b));
    sl = 6'h3F;
    sg = 8'hFF;
    if (on) begin
      sl[dg] = 1'b0;
      sg = ~{d[dg], segs[nib]};
    end
    return {tt % (8 * n) == 0, sl, sg};
  endfunction
  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      if (t % 32 == 0) begin s4_v = value; s4_d = dp; s4_e = en; s4_l = lz; end
      if (t % 48 == 0) begin s6_v = value; s6_d = dp; s6_e = en; s6_l = lz; end
      e4 = model(4, {8'h0, s4_v[15:0]}, s4_d, s4_e, s4_l, br, t);
      e6 = model(6, s6_v, s6_d, s6_e, s6_l, br, t);
      @(posedge clk);
      t++;
      @(negedge clk);
      check("seg4", 32'(b4.seg), 32'(e4[7:0]));
      check("sel4", 32'(b4.sel), 32'(e4[11:8]));
      check("fs4", 32'(b4.frame_start), 32'(e4[14]));
      check("seg6", 32'(b6.seg), 32'(e6[7:0]));
      check("sel6", 32'(b6.sel), 32'(e6[13:8]));
      check("fs6", 32'(b6.frame_start), 32'(e6[14]));
    end
  endtask
  task automatic check_reset();
    check("rst_seg4", 32'(b4.seg), 32'hFF);
    check("rst_sel4", 32'(b4.sel), 32'hF);
    check("rst_fs4", 32'(b4.frame_start), 32'h0);
    check("rst_seg6", 32'(b6.seg), 32'hFF);
    check("rst_sel6", 32'(b6.sel), 32'h3F);
    check("rst_fs6", 32'(b6.frame_start), 32'h0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    t = 0;
    run(96);
    br = 2'd1;
    run(96);
    br = 2'd0;
    run(96);
    br = 2'd3;
    value = 24'h000050;
    lz = 1'b1;
    dp = 6'b001000;
    run(96);
    value = 24'h0;
    run(96);
    lz = 1'b0;
    dp = 6'h0;
    value = 24'h111111;
    while (t % 96 != 12) run(1);
    value = 24'h222222;
    run(96);
    for (int r = 0; r < 30; r++) begin
      value = 24'($urandom) >> (4 * $urandom_range(0, 6));
      dp = 6'($urandom);
      en = 6'($urandom | $urandom);
      lz = 1'($urandom);
      br = 2'($urandom);
      run($urandom_range(1, 60));
    end
    value = 24'h561234;
    en = 6'h3F;
    lz = 1'b0;
    br = 2'd3;
    run(32);
    while (t % 32 != 20) run(1);
    #2 rst = 1'b1;
    #1 check_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset();
    #2 rst = 1'b0;
    t = 0;
    run(100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
